m706_rx: RTL and testbench

Asynchronous serial receiver that consumes the 8x-baud square wave produced by the variable-clock stage and deserialises the teletype/console line into parallel characters for the keyboard IOT logic. Samples an idle-high serial line at 8x oversampling, validates the start bit, and shifts in LSB-first data. Presents the character with a sticky ready flag that the processor clears by IOT. Sits between the baud clock generator and the KL8-style keyboard interface.

---
 rtl/m706_pkg.sv | 23 ++
 rtl/m706_sync_edge.sv | 46 ++++
 rtl/m706_rx.sv | 200 ++++++++++++++++++++
 tb/tb_m706_rx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m706_pkg.sv
// m706 serial receiver shared definitions: FSM states, oversampling
// ratio, mid-bit sample phase and the 2-of-3 vote used by the optional
// majority sampler (M706_MAJORITY_EN).
package m706_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Ticks per bit cell and the tick (counted from the bit edge) that lands mid-bit.
  localparam int OVERSAMPLE = 8;
  localparam int MID_PHASE  = 3;

  // 2-of-3 vote used when each bit is sampled three times around mid-bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/m706_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous level, with an
// optional one-cycle pulse on each rising edge of the synchronised level.
module sync_edge #(
  parameter bit RESET_VAL = 1'b0,
  parameter bit EDGE_EN   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_reg;

      // Delayed copy of the synchronised level for rising-edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_reg <= RESET_VAL;
        else        prev_reg <= sync_reg;
      end

      assign rise = sync_reg & ~prev_reg;
    end else begin : g_level
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/m706_rx.sv
// m706_rx: 8x-oversampled asynchronous serial receiver (idle-high line,
// LSB first) with sticky ready flag, framing error and overrun.
// Build option: define M706_MAJORITY_EN to take each bit as a 2-of-3 vote
// of the samples at phases 2, 3 and 4 instead of a single phase-3 sample.
module m706_rx
  import m706_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_8x,
  input  logic                 rx,
  input  logic                 flag_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 flag,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_EARLY = PW'(MID_PHASE - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(MID_PHASE);
`ifdef M706_MAJORITY_EN
  // The vote needs the phase-4 sample, so the decision waits one tick.
  localparam logic [PW-1:0] PH_DECIDE = PW'(MID_PHASE + 1);
`else
  localparam logic [PW-1:0] PH_DECIDE = PW'(MID_PHASE);
`endif
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic tick;
  logic rx_s;
  logic clk8_level_unused;
  logic rx_rise_unused;

  sync_edge #(.RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_clk8_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_8x),
    .q     (clk8_level_unused),
    .rise  (tick)
  );

  sync_edge #(.RESET_VAL(1'b1), .EDGE_EN(1'b0)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s),
    .rise  (rx_rise_unused)
  );

  rx_state_t            state_reg;
  logic [PW-1:0]        phase_reg;
  logic [3:0]           bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 stop_err_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 flag_reg;
  logic                 framing_err_reg;
  logic                 overrun_reg;
  logic                 busy_reg;

  logic [PW-1:0] phase_next;
  logic          sample_bit;
  logic          sample_now;
  logic          stop_err_next;
  logic          char_done;

  // Phase advances on every tick once a start edge has been seen.
  assign phase_next = phase_reg + 1'b1;
  assign sample_now = tick && (phase_next == PH_DECIDE);

`ifdef M706_MAJORITY_EN
  logic [1:0] early_reg;

  // Hold the phase-2 and phase-3 samples for the vote taken at phase 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_reg <= 2'b11;
    end else if (tick && (state_reg != IDLE)) begin
      if (phase_next == PH_EARLY) early_reg[0] <= rx_s;
      if (phase_next == PH_MID)   early_reg[1] <= rx_s;
    end
  end

  assign sample_bit = maj3(early_reg[0], early_reg[1], rx_s);
`else
  assign sample_bit = rx_s;
`endif

  assign stop_err_next = stop_err_reg | ~sample_bit;
  assign char_done     = sample_now && (state_reg == STOP) && (bit_cnt_reg == LAST_STOP);

  // Receive state machine with its counters, shift register and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      stop_err_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tick && !rx_s) begin
            state_reg   <= START;
            phase_reg   <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            phase_reg <= phase_next;
            if (sample_now) begin
              if (sample_bit) begin
                // Line went back high before mid-bit: treat it as noise.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (tick) begin
            phase_reg <= phase_next;
            if (sample_now) begin
              shift_reg <= {sample_bit, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt_reg == LAST_DATA) begin
                state_reg    <= STOP;
                bit_cnt_reg  <= '0;
                stop_err_reg <= 1'b0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            phase_reg <= phase_next;
            if (sample_now) begin
              if (bit_cnt_reg == LAST_STOP) begin
                // A bad stop bit parks in BREAK so a held-low line is not re-read.
                state_reg <= stop_err_next ? BREAK : IDLE;
                busy_reg  <= stop_err_next;
              end else begin
                bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                stop_err_reg <= stop_err_next;
              end
            end
          end
        end
        BREAK: begin
          if (tick && rx_s) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Character delivery and sticky status; a completion beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg        <= '0;
      flag_reg        <= 1'b0;
      framing_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else if (char_done) begin
      data_reg        <= shift_reg;
      flag_reg        <= 1'b1;
      framing_err_reg <= stop_err_next;
      overrun_reg     <= ~flag_clr & (overrun_reg | flag_reg);
    end else if (flag_clr) begin
      flag_reg        <= 1'b0;
      framing_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end
  end

  assign data        = data_reg;
  assign flag        = flag_reg;
  assign framing_err = framing_err_reg;
  assign overrun     = overrun_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_m706_rx.sv
// Self-checking bench for m706_rx: directed scenarios plus random frames,
// compared every cycle against a tick-level behavioural receiver model.
// Honours M706_MAJORITY_EN the same way the design does.
`timescale 1ns/1ps
module tb_m706_rx;

  localparam int NB   = 8;
  localparam int NS   = 1;
  localparam int BITC = 128;   // clk cycles per bit with clk_8x period 16
`ifdef M706_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif
  localparam int DEC = MAJ ? 4 : 3;   // tick of a bit cell where the bit is decided

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_8x = 1'b0;
  logic rx = 1'b1;
  logic flag_clr = 1'b0;
  logic [NB-1:0] data;
  logic flag, framing_err, overrun, busy;

  m706_rx #(.DATA_BITS(NB), .STOP_BITS(NS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_8x      (clk_8x),
    .rx          (rx),
    .flag_clr    (flag_clr),
    .data        (data),
    .flag        (flag),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #25 clk = ~clk;   // 20 MHz

  int cyc = 8;
  int checks = 0;
  int passes = 0;
  int nprint = 0;

  // Inputs driven in each of the last 8 cycles.
  bit h_rx [0:7];
  bit h_c8 [0:7];
  bit h_fc [0:7];

  // Behavioural model: ticks counted since the start edge was seen.
  bit          m_rcv, m_brk, m_err;
  int          m_t;
  bit          m_rxs [0:127];
  logic [NB-1:0] m_bits;
  logic [NB-1:0] exp_data;
  bit          exp_flag, exp_fe, exp_ov, exp_busy;

  // Advance the model by one DUT clock edge. Synchronised inputs reach
  // the receive logic three edges after being driven; flag_clr one edge.
  task automatic model_edge();
    bit tk, r, fc, done, bitv;
    int j;
    h_rx[cyc % 8] = rx;
    h_c8[cyc % 8] = clk_8x;
    h_fc[cyc % 8] = flag_clr;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        h_rx[i] = 1'b1;
        h_c8[i] = 1'b0;
      end
      m_rcv = 0; m_brk = 0; m_err = 0; m_t = 0;
      exp_data = '0; exp_flag = 0; exp_fe = 0; exp_ov = 0; exp_busy = 0;
      return;
    end
    tk   = h_c8[(cyc - 2) % 8] && !h_c8[(cyc - 3) % 8];
    r    = h_rx[(cyc - 2) % 8];
    fc   = h_fc[cyc % 8];
    done = 0;
    if (tk) begin
      if (m_brk) begin
        if (r) begin m_brk = 0; exp_busy = 0; end
      end else if (!m_rcv) begin
        if (!r) begin m_rcv = 1; exp_busy = 1; m_t = 0; m_rxs[0] = r; m_err = 0; end
      end else begin
        m_t++;
        m_rxs[m_t] = r;
        if (m_t >= DEC && ((m_t - DEC) % 8) == 0) begin
          j = (m_t - DEC) / 8;
          if (MAJ)
            bitv = (int'(m_rxs[8*j+2]) + int'(m_rxs[8*j+3]) + int'(m_rxs[8*j+4])) >= 2;
          else
            bitv = m_rxs[8*j+3];
          if (j == 0) begin
            if (bitv) begin m_rcv = 0; exp_busy = 0; end
          end else if (j <= NB) begin
            m_bits[j-1] = bitv;
          end else begin
            if (!bitv) m_err = 1;
            if (j == NB + NS) begin
              done  = 1;
              m_rcv = 0;
              if (m_err) m_brk = 1;
              else       exp_busy = 0;
            end
          end
        end
      end
    end
    if (done) begin
      exp_ov   = fc ? 1'b0 : (exp_ov | exp_flag);
      exp_flag = 1;
      exp_fe   = m_err;
      exp_data = m_bits;
    end else if (fc) begin
      exp_flag = 0; exp_fe = 0; exp_ov = 0;
    end
  endtask

  task automatic check_outputs();
    checks++;
    if (data === exp_data && flag === exp_flag && framing_err === exp_fe &&
        overrun === exp_ov && busy === exp_busy) begin
      passes++;
    end else if (nprint < 20) begin
      nprint++;
      $display("FAIL cycle_compare cyc=%0d got data=%h flag=%b fe=%b ov=%b busy=%b required data=%h flag=%b fe=%b ov=%b busy=%b",
               cyc, data, flag, framing_err, overrun, busy,
               exp_data, exp_flag, exp_fe, exp_ov, exp_busy);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s got %h required %h", name, act, req);
  endtask

  // One clock: model and compare the edge just taken, then open the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
    cyc++;
    clk_8x   = ((cyc % 16) < 8);
    flag_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // Drive one frame from the current cycle. glitch_bit is the frame bit
  // index (0 = start); glitch_len 1 flips the phase-3 sample cycle only,
  // longer lengths start at the phase-2 sample cycle. cut > 0 truncates.
  task automatic send_frame(input logic [NB-1:0] ch, input bit stop_val,
                            input int glitch_bit, input int glitch_len,
                            input bit fc_at_done, input int cut);
    int s, c, ncyc, b, gs, fcc;
    s    = cyc;
    c    = ((s + 15) / 16) * 16;
    ncyc = (cut > 0) ? cut : BITC * (1 + NB + NS);
    gs   = c + 16 * (8 * glitch_bit + ((glitch_len == 1) ? 3 : 2));
    fcc  = c + 16 * (8 * (NB + NS) + DEC) + 2;
    for (int i = 0; i < ncyc; i++) begin
      b = i / BITC;
      if (b == 0)       rx = 1'b0;
      else if (b <= NB) rx = ch[b-1];
      else              rx = stop_val;
      if (glitch_len > 0 && cyc >= gs && cyc < gs + glitch_len) rx = ~rx;
      if (fc_at_done && cyc == fcc) flag_clr = 1'b1;
      step();
    end
  endtask

  task automatic clear_flag();
    flag_clr = 1'b1;
    step();
    idle(3);
  endtask

  initial begin
    logic [NB-1:0] ch;
    logic [NB-1:0] glitch_exp;
    for (int i = 0; i < 8; i++) begin
      h_rx[i] = 1'b1; h_c8[i] = 1'b0; h_fc[i] = 1'b0;
    end
    m_rcv = 0; m_brk = 0; m_err = 0; m_t = 0; m_bits = '0;
    exp_data = '0; exp_flag = 0; exp_fe = 0; exp_ov = 0; exp_busy = 0;

    // Reset state.
    rst_n = 1'b0;
    repeat (4) step();
    check_lit("reset_data", 32'(data), 32'h0);
    check_lit("reset_flag", 32'(flag), 32'h0);
    check_lit("reset_fe", 32'(framing_err), 32'h0);
    check_lit("reset_ov", 32'(overrun), 32'h0);
    check_lit("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(40);

    // Clean 0x55.
    send_frame(8'h55, 1'b1, 0, 0, 1'b0, 0);
    idle(20);
    check_lit("c55_data", 32'(data), 32'h55);
    check_lit("c55_flag", 32'(flag), 32'h1);
    check_lit("c55_fe", 32'(framing_err), 32'h0);
    check_lit("c55_busy", 32'(busy), 32'h0);
    check_lit("model_c55_data", 32'(exp_data), 32'h55);
    clear_flag();
    check_lit("clr_flag", 32'(flag), 32'h0);

    // Two-tick low pulse is rejected as a false start.
    rx = 1'b0;
    repeat (32) step();
    idle(200);
    check_lit("pulse_flag", 32'(flag), 32'h0);
    check_lit("pulse_busy", 32'(busy), 32'h0);

    // Bad stop bit, then the line held low for 20 ticks.
    send_frame(8'hA3, 1'b0, 0, 0, 1'b0, 0);
    rx = 1'b0;
    repeat (320) step();
    check_lit("brk_fe", 32'(framing_err), 32'h1);
    check_lit("brk_flag", 32'(flag), 32'h1);
    check_lit("brk_data", 32'(data), 32'hA3);
    check_lit("brk_busy", 32'(busy), 32'h1);
    check_lit("brk_ov", 32'(overrun), 32'h0);
    idle(100);
    check_lit("brk_exit_busy", 32'(busy), 32'h0);
    clear_flag();

    // Overrun, then a clear that leaves data alone.
    send_frame(8'h41, 1'b1, 0, 0, 1'b0, 0);
    idle(30);
    send_frame(8'h42, 1'b1, 0, 0, 1'b0, 0);
    idle(30);
    check_lit("ovr_data", 32'(data), 32'h42);
    check_lit("ovr_ov", 32'(overrun), 32'h1);
    check_lit("model_ovr_ov", 32'(exp_ov), 32'h1);
    clear_flag();
    check_lit("ovr_clr_flag", 32'(flag), 32'h0);
    check_lit("ovr_clr_ov", 32'(overrun), 32'h0);
    check_lit("ovr_clr_fe", 32'(framing_err), 32'h0);
    check_lit("ovr_clr_data", 32'(data), 32'h42);

    // Clear landing on the completion edge of 0x7F while flag is already set.
    send_frame(8'h11, 1'b1, 0, 0, 1'b0, 0);
    idle(20);
    send_frame(8'h7F, 1'b1, 0, 0, 1'b1, 0);
    idle(20);
    check_lit("race_flag", 32'(flag), 32'h1);
    check_lit("race_ov", 32'(overrun), 32'h0);
    check_lit("race_data", 32'(data), 32'h7F);
    clear_flag();

    // One-clock glitch on the phase-3 sample of data bit 2.
    send_frame(8'hC4, 1'b1, 3, 1, 1'b0, 0);
    idle(20);
    glitch_exp = MAJ ? 8'hC4 : 8'hC0;
    check_lit("glitch1_data", 32'(data), 32'(glitch_exp));
    clear_flag();

    // Glitch covering the whole sample window of data bit 2.
    send_frame(8'h5A, 1'b1, 3, 33, 1'b0, 0);
    idle(20);
    check_lit("glitchw_data", 32'(data), 32'h5E);
    clear_flag();

    // Reset pulsed in the middle of a character while flag is set.
    send_frame(8'h99, 1'b1, 0, 0, 1'b0, 0);
    idle(20);
    send_frame(8'h3C, 1'b1, 0, 0, 1'b0, 600);
    rst_n = 1'b0;
    #1;
    check_lit("rst_mid_data", 32'(data), 32'h0);
    check_lit("rst_mid_flag", 32'(flag), 32'h0);
    check_lit("rst_mid_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    idle(200);
    send_frame(8'h3C, 1'b1, 0, 0, 1'b0, 0);
    idle(20);
    check_lit("post_rst_data", 32'(data), 32'h3C);
    check_lit("post_rst_flag", 32'(flag), 32'h1);
    check_lit("post_rst_fe", 32'(framing_err), 32'h0);
    clear_flag();

    // Random frames: characters, stop errors, glitches, clears and gaps.
    for (int n = 0; n < 25; n++) begin
      ch = NB'($urandom);
      send_frame(ch, ($urandom_range(0, 4) != 0), $urandom_range(1, NB),
                 (($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0),
                 1'b0, 0);
      rx = 1'b1;
      if ($urandom_range(0, 1) == 1) flag_clr = 1'b1;
      repeat ($urandom_range(1, 150)) step();
    end
    idle(200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
